// File: rtl/freq_div_pkg.sv
// Shared types and constants for the programmable clock divider.
package freq_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned MIN_DIV = 2;

endpackage

// File: rtl/freq_div_core.sv
// Period counter with terminal-count wrap and registered high-time compare.
module freq_div_core #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             run_nxt,
  input  logic [CNT_W-1:0] act_div,
  input  logic [CNT_W-1:0] high_nxt,
  output logic             wrap,
  output logic             div_out
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign wrap = run && (cnt == act_div - CNT_W'(1));

  // A fresh start from idle, a wrap, or stopping all return the count to zero.
  always_comb begin
    cnt_nxt = '0;
    if (run && run_nxt && !wrap) cnt_nxt = cnt + CNT_W'(1);
  end

  // div_out is registered from next-cycle values so it lines up with cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      div_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_out <= run_nxt && (cnt_nxt < high_nxt);
    end
  end

endmodule

// File: rtl/freq_div_ctrl.sv
// Divider control: run/drain sequencing, config handshake and pending-config
// holding registers that are applied on period boundaries.
//
//   state | meaning
//   IDLE  | stopped, counter held at 0, output low
//   RUN   | dividing, en asserted
//   DRAIN | en dropped, finishing the current period before stopping
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 10,
  parameter int DEF_HIGH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             div_out,
  output logic             period_start,
  output logic             cfg_applied,
  output logic             cfg_err,
  output logic             busy
);

  localparam int DEF_HIGH_CLAMP = (DEF_HIGH > DEF_DIV) ? DEF_DIV : DEF_HIGH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] act_div_q, act_div_d;
  logic [CNT_W-1:0] act_high_q, act_high_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic [CNT_W-1:0] pend_high_q, pend_high_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cfg_high_clamp;
  logic             accept, legal, apply;
  logic             run, run_nxt, wrap;

  assign run       = (state_q != IDLE);
  assign run_nxt   = (state_d != IDLE);
  assign busy      = run;
  assign cfg_ready = !pend_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)        state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept         = cfg_valid && !pend_q;
  assign legal          = (cfg_div >= CNT_W'(MIN_DIV));
  assign cfg_high_clamp = (cfg_high > cfg_div) ? cfg_div : cfg_high;

  // A legal request lands immediately when idle or on a wrap cycle;
  // otherwise it waits in the holding registers for the next boundary.
  always_comb begin
    act_div_d   = act_div_q;
    act_high_d  = act_high_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    pend_high_d = pend_high_q;
    apply       = 1'b0;
    if (accept && legal) begin
      if (!run || wrap) begin
        act_div_d  = cfg_div;
        act_high_d = cfg_high_clamp;
        apply      = 1'b1;
      end else begin
        pend_d      = 1'b1;
        pend_div_d  = cfg_div;
        pend_high_d = cfg_high_clamp;
      end
    end else if (pend_q && wrap) begin
      act_div_d  = pend_div_q;
      act_high_d = pend_high_q;
      pend_d     = 1'b0;
      apply      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      act_div_q    <= CNT_W'(DEF_DIV);
      act_high_q   <= CNT_W'(DEF_HIGH_CLAMP);
      pend_q       <= 1'b0;
      pend_div_q   <= '0;
      pend_high_q  <= '0;
      period_start <= 1'b0;
      cfg_applied  <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_div_q    <= act_div_d;
      act_high_q   <= act_high_d;
      pend_q       <= pend_d;
      pend_div_q   <= pend_div_d;
      pend_high_q  <= pend_high_d;
      period_start <= run_nxt && (!run || wrap);
      cfg_applied  <= apply;
      cfg_err      <= accept && !legal;
    end
  end

  freq_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .run_nxt  (run_nxt),
    .act_div  (act_div_q),
    .high_nxt (act_high_d),
    .wrap     (wrap),
    .div_out  (div_out)
  );

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Bench for freq_div_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_freq_div_ctrl;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [CNT_W-1:0] cfg_div = '0;
  logic [CNT_W-1:0] cfg_high = '0;
  logic             cfg_ready, div_out, period_start, cfg_applied, cfg_err, busy;

  freq_div_ctrl #(.CNT_W(CNT_W), .DEF_DIV(10), .DEF_HIGH(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_div      (cfg_div),
    .cfg_high     (cfg_high),
    .div_out      (div_out),
    .period_start (period_start),
    .cfg_applied  (cfg_applied),
    .cfg_err      (cfg_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: mode 0 stopped, 1 running, 2 finishing last period.
  bit m_valid = 1'b0;
  int m_mode, m_pos, m_div, m_high, m_pdiv, m_phigh, m_next;
  bit m_pend, m_running, m_wrap, m_acc, m_legal, m_applied;
  int m_hi;
  bit e_div, e_ps, e_ca, e_err;

  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_div = 10; m_high = 7; m_pend = 1'b0;
      e_div = 1'b0; e_ps = 1'b0; e_ca = 1'b0; e_err = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_running = (m_mode != 0);
      m_wrap    = m_running && (m_pos == m_div - 1);
      m_acc     = cfg_valid && !m_pend;
      m_legal   = int'(cfg_div) >= 2;
      m_hi      = (int'(cfg_high) > int'(cfg_div)) ? int'(cfg_div) : int'(cfg_high);
      m_applied = 1'b0;
      if (m_acc && m_legal) begin
        if (!m_running || m_wrap) begin
          m_div = int'(cfg_div); m_high = m_hi; m_applied = 1'b1;
        end else begin
          m_pend = 1'b1; m_pdiv = int'(cfg_div); m_phigh = m_hi;
        end
      end else if (m_pend && m_wrap) begin
        m_div = m_pdiv; m_high = m_phigh; m_pend = 1'b0; m_applied = 1'b1;
      end
      m_next = m_mode;
      if (m_mode == 0 && en) m_next = 1;
      else if (m_mode == 1 && !en) m_next = 2;
      else if (m_mode == 2) m_next = en ? 1 : (m_wrap ? 0 : 2);
      if (m_next == 0 || !m_running || m_wrap) m_pos = 0;
      else m_pos = m_pos + 1;
      e_ps  = (m_next != 0) && (!m_running || m_wrap);
      e_div = (m_next != 0) && (m_pos < m_high);
      e_ca  = m_applied;
      e_err = m_acc && !m_legal;
      m_mode = m_next;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model div_out",      div_out,      e_div);
      chk("model period_start", period_start, e_ps);
      chk("model cfg_applied",  cfg_applied,  e_ca);
      chk("model cfg_err",      cfg_err,      e_err);
      chk("model busy",         busy,         m_mode != 0);
      chk("model cfg_ready",    cfg_ready,    !m_pend);
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset cfg_ready", cfg_ready, 1'b1);
    chk("reset div_out", div_out, 1'b0);
    chk("reset period_start", period_start, 1'b0);

    // defaults: 10-cycle period, 7 high
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("default div_out", div_out, (i % 10) < 7);
      chk("default period_start", period_start, (i % 10) == 0);
    end

    // request 4/1 at cnt=3; it waits for the boundary
    repeat (4) tick();
    cfg_valid = 1'b1; cfg_div = 16'd4; cfg_high = 16'd1;
    tick();
    cfg_valid = 1'b0;
    chk("pending cfg_ready", cfg_ready, 1'b0);
    for (int i = 5; i < 10; i++) begin
      tick();
      chk("pending cfg_ready hold", cfg_ready, 1'b0);
      chk("old period div_out", div_out, i < 7);
    end
    tick();
    chk("boundary period_start", period_start, 1'b1);
    chk("boundary cfg_applied", cfg_applied, 1'b1);
    chk("boundary cfg_ready", cfg_ready, 1'b1);
    chk("boundary div_out", div_out, 1'b1);
    for (int i = 1; i < 8; i++) begin
      tick();
      chk("div4 div_out", div_out, (i % 4) == 0);
      chk("div4 period_start", period_start, (i % 4) == 0);
    end

    // illegal divisor while running
    cfg_valid = 1'b1; cfg_div = 16'd1; cfg_high = 16'd0;
    tick();
    cfg_valid = 1'b0;
    chk("run cfg_err", cfg_err, 1'b1);
    chk("run cfg_err no apply", cfg_applied, 1'b0);
    tick();
    chk("cfg_err single pulse", cfg_err, 1'b0);
    chk("div4 kept after err", div_out, 1'b0);

    en = 1'b0;
    for (int k = 0; k < 40 && busy; k++) tick();
    chk("drain reached idle", busy, 1'b0);

    cfg_valid = 1'b1; cfg_div = 16'd0;
    tick();
    cfg_valid = 1'b0;
    chk("idle cfg_err", cfg_err, 1'b1);
    chk("idle err no apply", cfg_applied, 1'b0);

    // 5/9 clamps to constant high
    cfg_valid = 1'b1; cfg_div = 16'd5; cfg_high = 16'd9;
    tick();
    cfg_valid = 1'b0;
    chk("idle cfg_applied", cfg_applied, 1'b1);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("clamped div_out", div_out, 1'b1);
      chk("clamped period_start", period_start, (i % 5) == 0);
    end

    // request on the wrap cycle itself lands at that boundary
    cfg_valid = 1'b1; cfg_div = 16'd5; cfg_high = 16'd0;
    tick();
    cfg_valid = 1'b0;
    chk("wrap-cycle cfg_applied", cfg_applied, 1'b1);
    chk("wrap-cycle period_start", period_start, 1'b1);
    chk("wrap-cycle cfg_ready", cfg_ready, 1'b1);
    chk("zero-high div_out", div_out, 1'b0);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("zero-high div_out run", div_out, 1'b0);
      chk("zero-high period_start", period_start, (i % 5) == 0);
    end

    // reset mid-period with a pending config
    tick();
    cfg_valid = 1'b1; cfg_div = 16'd6; cfg_high = 16'd2;
    tick();
    cfg_valid = 1'b0;
    chk("pre-reset pending", cfg_ready, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid reset div_out", div_out, 1'b0);
    chk("mid reset period_start", period_start, 1'b0);
    chk("mid reset cfg_applied", cfg_applied, 1'b0);
    chk("mid reset cfg_err", cfg_err, 1'b0);
    chk("mid reset busy", busy, 1'b0);
    chk("mid reset cfg_ready", cfg_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("post-reset div_out", div_out, (i % 10) < 7);
      chk("post-reset period_start", period_start, (i % 10) == 0);
    end

    // randomized traffic, model-checked every cycle
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst       = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) en = ~en;
      cfg_valid = ($urandom_range(0, 11) == 0);
      cfg_div   = 16'($urandom_range(0, 12));
      cfg_high  = 16'($urandom_range(0, 14));
    end
    rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
